// File: rtl/id_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_scoreboard_pkg
// Purpose  : Shared constants and types for the ID-stage register scoreboard.
//            Supplies default widths, the untracked zero register index, the
//            per-register counter type and its saturation value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package id_scoreboard_pkg;

  localparam int unsigned SB_NUM_REGS = 32;
  localparam int unsigned SB_IDX_W    = 5;
  localparam int unsigned SB_CNT_W    = 2;

  // Register 0 is hard-wired to zero and never carries a pending write.
  localparam int unsigned ZERO_REG    = 0;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage : id_scoreboard_pkg
`default_nettype wire

// File: rtl/id_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : id_scoreboard_if
// Purpose  : Bundles the decoder-side request, MEM/WB retire information and
//            the scoreboard status outputs.
// Modports : master - decoder/pipeline side (drives id_* and wb_* requests)
//            slave  - scoreboard side (drives hazard, issue, pending, err)
// Revision : 1.0 - initial release
// ============================================================================
interface id_scoreboard_if
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = SB_NUM_REGS,
  parameter int unsigned IDX_W    = SB_IDX_W
);

  logic                id_valid_inst;
  logic [IDX_W-1:0]    id_ra_idx;
  logic                id_ra_used;
  logic [IDX_W-1:0]    id_rb_idx;
  logic                id_rb_used;
  logic                id_reg_wr;
  logic [IDX_W-1:0]    id_dest_reg_idx;
  logic                id_rd_mem;
  logic                id_flush;
  logic                wb_retire;
  logic                wb_reg_wr;
  logic [IDX_W-1:0]    wb_dest_reg_idx;
  logic                id_hazard_flag;
  logic                id_issue;
  logic [NUM_REGS-1:0] sb_pending;
  logic                sb_err;

  modport master (
    output id_valid_inst, id_ra_idx, id_ra_used, id_rb_idx, id_rb_used,
           id_reg_wr, id_dest_reg_idx, id_rd_mem, id_flush,
           wb_retire, wb_reg_wr, wb_dest_reg_idx,
    input  id_hazard_flag, id_issue, sb_pending, sb_err
  );

  modport slave (
    input  id_valid_inst, id_ra_idx, id_ra_used, id_rb_idx, id_rb_used,
           id_reg_wr, id_dest_reg_idx, id_rd_mem, id_flush,
           wb_retire, wb_reg_wr, wb_dest_reg_idx,
    output id_hazard_flag, id_issue, sb_pending, sb_err
  );

endinterface : id_scoreboard_if
`default_nettype wire

// File: rtl/id_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module   : id_scoreboard_sb_counter
// Purpose  : Outstanding-write counter for one architectural register.
//            Counts up on issue, down on retire, holds when both happen in
//            the same cycle, never wraps in either direction.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            inc, dec      - issue / retire strobes for this register
//            cnt           - current outstanding-write count
//            is_zero       - cnt == 0
//            is_max        - cnt == all ones
//            underflow     - retire seen with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module id_scoreboard_sb_counter
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc,
  input  wire logic             dec,
  output logic      [CNT_W-1:0] cnt,
  output logic                  is_zero,
  output logic                  is_max,
  output logic                  underflow
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && !dec && !is_max) begin
      r_cnt <= r_cnt + c_one;
    end else if (dec && !inc && !is_zero) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  assign cnt       = r_cnt;
  assign is_zero   = (r_cnt == '0);
  assign is_max    = (r_cnt == '1);
  // A simultaneous issue cancels the retire, so only a lone retire on an
  // empty counter is an error.
  assign underflow = dec & ~inc & is_zero;

endmodule : id_scoreboard_sb_counter
`default_nettype wire

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_scoreboard
// Purpose  : ID-stage register scoreboard. Tracks in-flight writes per
//            architectural register and raises a same-cycle hazard flag for
//            RAW dependencies (or load-use only when forwarding exists) and
//            for counter saturation.
// Ports    : clk  - system clock
//            rst  - asynchronous active-high reset
//            sb   - id_scoreboard_if.slave: decoder request, MEM/WB retire,
//                   id_hazard_flag, id_issue, sb_pending, sb_err
// Revision : 1.0 - initial release
// ============================================================================
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS  = SB_NUM_REGS,
  parameter int unsigned IDX_W     = SB_IDX_W,
  parameter int unsigned CNT_W     = SB_CNT_W,
  parameter bit          FWD_EN    = 1'b0,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  id_scoreboard_if.slave sb
);

  localparam logic [IDX_W-1:0] c_zero = IDX_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [CNT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_is_zero;
  logic [NUM_REGS-1:0] w_is_max;
  logic [NUM_REGS-1:1] w_underflow;

  logic             w_inc;
  logic             w_dec;
  logic             w_issue;
  logic             w_hazard;
  logic             w_dec_ra;
  logic             w_dec_rb;
  logic             w_dec_dst;
  logic             w_cnt_hz_ra;
  logic             w_cnt_hz_rb;
  logic             w_fwd_hz_ra;
  logic             w_fwd_hz_rb;
  logic             w_src_hz_ra;
  logic             w_src_hz_rb;
  logic             w_sat_hz;

  logic             r_ld_vld;
  logic [IDX_W-1:0] r_ld_idx;
  logic             r_sb_err;

  // --------------------------------------------------------------------------
  // Per-register counters; register 0 is tied off as permanently empty.
  // --------------------------------------------------------------------------
  assign w_cnt[0]     = '0;
  assign w_is_zero[0] = 1'b1;
  assign w_is_max[0]  = 1'b0;

  assign w_inc = w_issue & sb.id_reg_wr & (sb.id_dest_reg_idx != c_zero);
  assign w_dec = sb.wb_retire & sb.wb_reg_wr & (sb.wb_dest_reg_idx != c_zero);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    id_scoreboard_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_inc & (sb.id_dest_reg_idx == IDX_W'(r))),
      .dec       (w_dec & (sb.wb_dest_reg_idx == IDX_W'(r))),
      .cnt       (w_cnt[r]),
      .is_zero   (w_is_zero[r]),
      .is_max    (w_is_max[r]),
      .underflow (w_underflow[r])
    );
  end

  assign sb.sb_pending[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    assign sb.sb_pending[r] = ~rst & ~w_is_zero[r];
  end

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  // A retire of the same register this cycle: only the counter path and the
  // saturation check look at it, and w_dec already excludes register 0.
  assign w_dec_ra  = w_dec & (sb.wb_dest_reg_idx == sb.id_ra_idx);
  assign w_dec_rb  = w_dec & (sb.wb_dest_reg_idx == sb.id_rb_idx);
  assign w_dec_dst = w_dec & (sb.wb_dest_reg_idx == sb.id_dest_reg_idx);

  // Without forwarding: any pending write is a hazard, unless it is the last
  // one and is being written back right now (register-file bypass).
  assign w_cnt_hz_ra = sb.id_ra_used & (sb.id_ra_idx != c_zero) & ~w_is_zero[sb.id_ra_idx]
                     & ~(WB_BYPASS & (w_cnt[sb.id_ra_idx] == c_one) & w_dec_ra);
  assign w_cnt_hz_rb = sb.id_rb_used & (sb.id_rb_idx != c_zero) & ~w_is_zero[sb.id_rb_idx]
                     & ~(WB_BYPASS & (w_cnt[sb.id_rb_idx] == c_one) & w_dec_rb);

  // With forwarding: only a load issued in the previous cycle cannot be
  // forwarded in time.
  assign w_fwd_hz_ra = sb.id_ra_used & (sb.id_ra_idx != c_zero) & r_ld_vld
                     & (r_ld_idx == sb.id_ra_idx);
  assign w_fwd_hz_rb = sb.id_rb_used & (sb.id_rb_idx != c_zero) & r_ld_vld
                     & (r_ld_idx == sb.id_rb_idx);

  assign w_src_hz_ra = FWD_EN ? w_fwd_hz_ra : w_cnt_hz_ra;
  assign w_src_hz_rb = FWD_EN ? w_fwd_hz_rb : w_cnt_hz_rb;

  // A full counter cannot take another writer unless one retires this cycle.
  assign w_sat_hz = sb.id_reg_wr & (sb.id_dest_reg_idx != c_zero)
                  & w_is_max[sb.id_dest_reg_idx] & ~w_dec_dst;

  assign w_hazard = ~rst & sb.id_valid_inst & (w_src_hz_ra | w_src_hz_rb | w_sat_hz);
  assign w_issue  = ~rst & sb.id_valid_inst & ~w_hazard & ~sb.id_flush;

  assign sb.id_hazard_flag = w_hazard;
  assign sb.id_issue       = w_issue;

  // --------------------------------------------------------------------------
  // Load tracker: remembers a load issued last cycle; any cycle without an
  // issuing load clears it, so a load-use stall lasts exactly one cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_vld <= 1'b0;
      r_ld_idx <= '0;
    end else begin
      r_ld_vld <= w_inc & sb.id_rd_mem;
      r_ld_idx <= sb.id_dest_reg_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky underflow error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else if (|w_underflow) begin
      r_sb_err <= 1'b1;
    end
  end

  assign sb.sb_err = r_sb_err;

endmodule : id_scoreboard
`default_nettype wire

// File: tb/tb_id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_scoreboard
// Purpose  : Directed self-checking bench for id_scoreboard. Instance 0 runs
//            without forwarding, instance 1 with load-use-only stalling.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_scoreboard;

  logic clk;
  logic rst;

  int n_chk;
  int n_bad;

  id_scoreboard_if #(.NUM_REGS(32), .IDX_W(5)) if0 ();
  id_scoreboard_if #(.NUM_REGS(32), .IDX_W(5)) if1 ();

  id_scoreboard #(
    .NUM_REGS(32), .IDX_W(5), .CNT_W(2), .FWD_EN(1'b0), .WB_BYPASS(1'b1)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .sb  (if0)
  );

  id_scoreboard #(
    .NUM_REGS(32), .IDX_W(5), .CNT_W(2), .FWD_EN(1'b1), .WB_BYPASS(1'b1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .sb  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inst0(input logic v, input logic [4:0] ra, input logic rau,
                       input logic [4:0] rb, input logic rbu, input logic wr,
                       input logic [4:0] d, input logic mem, input logic fl);
    if0.id_valid_inst = v;   if0.id_ra_idx = ra; if0.id_ra_used = rau;
    if0.id_rb_idx = rb;      if0.id_rb_used = rbu;
    if0.id_reg_wr = wr;      if0.id_dest_reg_idx = d;
    if0.id_rd_mem = mem;     if0.id_flush = fl;
  endtask

  task automatic inst1(input logic v, input logic [4:0] ra, input logic rau,
                       input logic [4:0] rb, input logic rbu, input logic wr,
                       input logic [4:0] d, input logic mem, input logic fl);
    if1.id_valid_inst = v;   if1.id_ra_idx = ra; if1.id_ra_used = rau;
    if1.id_rb_idx = rb;      if1.id_rb_used = rbu;
    if1.id_reg_wr = wr;      if1.id_dest_reg_idx = d;
    if1.id_rd_mem = mem;     if1.id_flush = fl;
  endtask

  task automatic ret0(input logic r, input logic wr, input logic [4:0] d);
    if0.wb_retire = r; if0.wb_reg_wr = wr; if0.wb_dest_reg_idx = d;
  endtask

  task automatic ret1(input logic r, input logic wr, input logic [4:0] d);
    if1.wb_retire = r; if1.wb_reg_wr = wr; if1.wb_dest_reg_idx = d;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst   = 1'b1;
    inst0(1, 0, 0, 0, 0, 1, 5, 0, 0);   // add x5 held during reset
    ret0(0, 0, 0);
    inst1(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ret1(0, 0, 0);

    // ---- reset state ----
    #2;
    check("rst_issue",   32'(if0.id_issue),       32'h0);
    check("rst_hazard",  32'(if0.id_hazard_flag), 32'h0);
    check("rst_pending", if0.sb_pending,          32'h0);
    check("rst_err",     32'(if0.sb_err),         32'h0);
    tick();
    check("rst_pending_edge", if0.sb_pending, 32'h0);
    rst = 1'b0;

    // ---- RAW hazard without forwarding, released by WB bypass ----
    #1;
    check("add_x5_issue", 32'(if0.id_issue), 32'h1);
    tick();                                        // cnt5=1
    inst0(1, 5, 1, 0, 1, 1, 6, 0, 0);              // add x6,x5,x0
    #1;
    check("raw_hazard",  32'(if0.id_hazard_flag), 32'h1);
    check("raw_noissue", 32'(if0.id_issue),       32'h0);
    check("raw_pending", if0.sb_pending,          32'h0000_0020);
    tick();
    check("raw_hold", 32'(if0.id_hazard_flag), 32'h1);
    ret0(1, 1, 5);
    #1;
    check("bypass_hazard", 32'(if0.id_hazard_flag), 32'h0);
    check("bypass_issue",  32'(if0.id_issue),       32'h1);
    tick();                                        // cnt5=0, cnt6=1
    inst0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ret0(0, 0, 0);
    #1;
    check("after_bypass_pending", if0.sb_pending, 32'h0000_0040);
    ret0(1, 1, 6);
    tick();
    ret0(0, 0, 0);

    // ---- no same-cycle self hazard ----
    inst0(1, 10, 1, 10, 1, 1, 10, 0, 0);           // add x10,x10,x10
    #1;
    check("self_issue", 32'(if0.id_issue), 32'h1);
    tick();
    inst0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ret0(1, 1, 10);
    tick();
    ret0(0, 0, 0);
    #1;
    check("clean_pending", if0.sb_pending, 32'h0);

    // ---- same-cycle issue and retire of x9 ----
    inst0(1, 0, 0, 0, 0, 1, 9, 0, 0);
    tick();                                        // cnt9=1
    ret0(1, 1, 9);
    #1;
    check("x9_issue", 32'(if0.id_issue), 32'h1);
    tick();                                        // cnt9 stays 1
    inst0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ret0(0, 0, 0);
    #1;
    check("x9_pending", if0.sb_pending, 32'h0000_0200);
    ret0(1, 1, 9);
    tick();
    ret0(0, 0, 0);
    #1;
    check("x9_drained", if0.sb_pending, 32'h0);

    // ---- saturation on x3 ----
    inst0(1, 0, 0, 0, 0, 1, 3, 0, 0);
    tick(); tick(); tick();                        // cnt3=3
    check("sat_hazard",  32'(if0.id_hazard_flag), 32'h1);
    check("sat_noissue", 32'(if0.id_issue),       32'h0);
    tick();
    ret0(1, 1, 3);
    #1;
    check("sat_retire_hazard", 32'(if0.id_hazard_flag), 32'h0);
    check("sat_retire_issue",  32'(if0.id_issue),       32'h1);
    tick();                                        // cnt3 stays 3
    inst0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();                                // cnt3=1
    check("sat_one_left", if0.sb_pending, 32'h0000_0008);
    tick();                                        // cnt3=0
    ret0(0, 0, 0);
    check("sat_drained", if0.sb_pending, 32'h0);

    // ---- x0 and unused sources, underflow ----
    inst0(1, 0, 1, 0, 1, 1, 0, 0, 0);              // add x0,x0,x0
    #1;
    check("x0_hazard", 32'(if0.id_hazard_flag), 32'h0);
    check("x0_issue",  32'(if0.id_issue),       32'h1);
    tick();
    check("x0_pending", if0.sb_pending, 32'h0);
    inst0(1, 0, 0, 0, 0, 1, 4, 0, 0);
    tick();                                        // cnt4=1
    inst0(1, 4, 0, 4, 0, 0, 12, 0, 0);             // matching idx, not used
    #1;
    check("unused_hazard", 32'(if0.id_hazard_flag), 32'h0);
    check("unused_issue",  32'(if0.id_issue),       32'h1);
    tick();
    inst0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ret0(1, 1, 4);
    tick();                                        // cnt4=0
    check("x4_drained", if0.sb_pending, 32'h0);
    check("no_err_yet", 32'(if0.sb_err), 32'h0);
    tick();                                        // underflow
    ret0(0, 0, 0);
    check("uf_err",     32'(if0.sb_err),  32'h1);
    check("uf_pending", if0.sb_pending,   32'h0);
    tick();
    check("uf_sticky",  32'(if0.sb_err),  32'h1);

    // ---- flush ----
    inst0(1, 0, 0, 0, 0, 1, 5, 0, 0);
    tick();                                        // cnt5=1
    inst0(1, 5, 1, 0, 0, 1, 6, 0, 1);              // hazard and flush
    #1;
    check("flush_hz_hazard", 32'(if0.id_hazard_flag), 32'h1);
    check("flush_hz_issue",  32'(if0.id_issue),       32'h0);
    tick();
    inst0(1, 0, 0, 0, 0, 1, 11, 0, 1);             // flush, no hazard
    #1;
    check("flush_issue", 32'(if0.id_issue), 32'h0);
    tick();
    inst0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("flush_pending", if0.sb_pending, 32'h0000_0020);

    // ---- load-use with forwarding (instance 1) ----
    inst1(1, 0, 0, 0, 0, 1, 7, 1, 0);              // lw x7
    #1;
    check("lw_issue", 32'(if1.id_issue), 32'h1);
    tick();
    inst1(1, 7, 1, 7, 1, 1, 8, 0, 0);              // add x8,x7,x7
    #1;
    check("lu_hazard",  32'(if1.id_hazard_flag), 32'h1);
    check("lu_noissue", 32'(if1.id_issue),       32'h0);
    tick();
    check("lu_release_hazard", 32'(if1.id_hazard_flag), 32'h0);
    check("lu_release_issue",  32'(if1.id_issue),       32'h1);
    tick();
    inst1(1, 8, 1, 8, 1, 1, 9, 0, 0);              // add x9,x8,x8
    #1;
    check("addadd_hazard", 32'(if1.id_hazard_flag), 32'h0);
    check("addadd_issue",  32'(if1.id_issue),       32'h1);
    tick();

    // ---- asynchronous reset mid-stream ----
    inst0(1, 0, 0, 0, 0, 1, 5, 0, 0);              // cnt5 -> 2
    inst1(1, 0, 0, 0, 0, 1, 7, 1, 0);              // lw x7 -> load tracked
    tick();
    inst0(1, 5, 1, 0, 0, 1, 6, 0, 0);              // add x6,x5
    inst1(1, 7, 1, 0, 0, 1, 8, 0, 0);              // add x8,x7
    #1;
    check("pre_rst_hazard0", 32'(if0.id_hazard_flag), 32'h1);
    check("pre_rst_hazard1", 32'(if1.id_hazard_flag), 32'h1);
    rst = 1'b1;
    #1;
    check("arst_pending", if0.sb_pending,    32'h0);
    check("arst_issue0",  32'(if0.id_issue), 32'h0);
    check("arst_issue1",  32'(if1.id_issue), 32'h0);
    check("arst_err",     32'(if0.sb_err),   32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_issue0",  32'(if0.id_issue),       32'h1);
    check("post_rst_hazard0", 32'(if0.id_hazard_flag), 32'h0);
    check("post_rst_issue1",  32'(if1.id_issue),       32'h1);
    check("post_rst_hazard1", 32'(if1.id_hazard_flag), 32'h0);
    tick();
    inst0(0, 0, 0, 0, 0, 0, 0, 0, 0);
    inst1(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_pending", if0.sb_pending, 32'h0000_0040);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_id_scoreboard
`default_nettype wire
